pong_game_controller: RTL and testbench

- Sequences a single-player pong game: serve, ball motion, wall/paddle collisions, miss handling, scoring and game over.
- Advances once per video frame on a frame tick.
- Publishes ball position and game status for the pixel-generation logic, which draws the ball alongside border, net and paddle.
- Sits between the paddle-position input path and the screen renderer, in the SYSTEM_CLOCK domain.

---
 rtl/pong_game_controller_pkg.sv | 33 +++
 rtl/pong_game_controller_if.sv | 21 ++
 rtl/pong_game_controller_ball_physics.sv | 66 ++++++
 rtl/pong_game_controller.sv | 155 +++++++++++++++
 tb/tb_pong_game_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_game_controller_pkg.sv
// Shared state encoding, screen/paddle geometry and helpers for the pong controller.
package pong_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_MISS, ST_OVER} state_e;
    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_SERVE = 2'b01,
        GS_PLAY  = 2'b10,
        GS_OVER  = 2'b11
    } game_state_e;

    localparam int SCREEN_V_LIM  = 478;
    localparam int SCREEN_H_LIM  = 778;
    localparam int CENTER_H      = 385;
    localparam int CENTER_V      = 235;
    localparam int PADDLE_H_MIN  = 10;
    localparam int PADDLE_H_MAX  = 20;
    localparam int PADDLE_HEIGHT = 50;
    localparam int PADDLE_SHIFT  = 4;

    // MISS shares the SERVE code: the renderer only cares that play is paused.
    function automatic game_state_e report_state(input state_e s);
        case (s)
            ST_IDLE:           return GS_IDLE;
            ST_SERVE, ST_MISS: return GS_SERVE;
            ST_PLAY:           return GS_PLAY;
            default:           return GS_OVER;
        endcase
    endfunction

    function automatic logic [10:0] paddle_top(input logic [7:0] pos);
        return {3'b000, pos} << PADDLE_SHIFT;
    endfunction
endpackage

// File: rtl/pong_game_controller_if.sv
// Frame/paddle inputs and ball/status outputs between the game controller and the renderer.
interface pong_game_controller_if;
    logic        FRAME_TICK;
    logic        START;
    logic [7:0]  PADDLE_POSITION;
    logic [10:0] BALL_H;
    logic [10:0] BALL_V;
    logic        BALL_VISIBLE;
    logic [7:0]  SCORE;
    logic [1:0]  LIVES_LEFT;
    logic [1:0]  GAME_STATE;

    modport master (
        output FRAME_TICK, START, PADDLE_POSITION,
        input  BALL_H, BALL_V, BALL_VISIBLE, SCORE, LIVES_LEFT, GAME_STATE
    );
    modport slave (
        input  FRAME_TICK, START, PADDLE_POSITION,
        output BALL_H, BALL_V, BALL_VISIBLE, SCORE, LIVES_LEFT, GAME_STATE
    );
endinterface

// File: rtl/pong_game_controller_ball_physics.sv
// Combinational one-frame ball step: wall reflections and left-edge paddle hit/miss.
module ball_physics
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = 8
) (
    input  logic [10:0]       ball_h,
    input  logic [10:0]       ball_v,
    input  logic signed [3:0] dx,
    input  logic signed [3:0] dy,
    input  logic [10:0]       pad_top,
    output logic [10:0]       nxt_h,
    output logic [10:0]       nxt_v,
    output logic signed [3:0] nxt_dx,
    output logic signed [3:0] nxt_dy,
    output logic              hit,
    output logic              miss
);
    localparam logic signed [11:0] TOP_LIM   = 12'sd0;
    localparam logic signed [11:0] BOT_LIM   = 12'(SCREEN_V_LIM - BALL_SIZE);
    localparam logic signed [11:0] RIGHT_LIM = 12'(SCREEN_H_LIM - BALL_SIZE);
    localparam logic signed [11:0] LEFT_LIM  = 12'(PADDLE_H_MAX);

    logic signed [11:0] nh;
    logic signed [11:0] nv;
    logic [11:0]        ball_bot;
    logic [11:0]        pad_bot;
    logic               pad_overlap;

    always_comb begin
        nh = $signed({1'b0, ball_h}) + $signed({{8{dx[3]}}, dx});
        nv = $signed({1'b0, ball_v}) + $signed({{8{dy[3]}}, dy});
        // Paddle test uses the pre-move row so a grazing ball is judged where it was drawn.
        ball_bot    = {1'b0, ball_v} + 12'(BALL_SIZE - 1);
        pad_bot     = {1'b0, pad_top} + 12'(PADDLE_HEIGHT);
        pad_overlap = (ball_bot >= {1'b0, pad_top}) && ({1'b0, ball_v} <= pad_bot);

        nxt_v  = nv[10:0];
        nxt_dy = dy;
        if (dy < 4'sd0 && nv <= TOP_LIM) begin
            nxt_v  = 11'd1;
            nxt_dy = -dy;
        end else if (dy > 4'sd0 && nv >= BOT_LIM) begin
            nxt_v  = 11'(SCREEN_V_LIM - 1 - BALL_SIZE);
            nxt_dy = -dy;
        end

        nxt_h  = nh[10:0];
        nxt_dx = dx;
        hit    = 1'b0;
        miss   = 1'b0;
        if (dx > 4'sd0 && nh >= RIGHT_LIM) begin
            nxt_h  = 11'(SCREEN_H_LIM - 1 - BALL_SIZE);
            nxt_dx = -dx;
        end else if (dx < 4'sd0 && nh <= LEFT_LIM) begin
            if (pad_overlap) begin
                hit    = 1'b1;
                nxt_h  = 11'(PADDLE_H_MAX + 1);
                nxt_dx = -dx;
            end else begin
                miss   = 1'b1;
                nxt_h  = ball_h;
            end
        end
    end
endmodule

// File: rtl/pong_game_controller.sv
// Single-player pong sequencer: serve, play, miss and game-over, stepped once per frame tick.
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90,
    parameter int LIVES        = 3
) (
    input  logic                   SYSTEM_CLOCK,
    input  logic                   RESET,
    pong_game_controller_if.slave  bus
);
    localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic signed [3:0] SPEED_V = 4'(SPEED);

    state_e            state_q, state_d;
    logic [10:0]       ball_h_q, ball_h_d;
    logic [10:0]       ball_v_q, ball_v_d;
    logic signed [3:0] dx_q, dx_d;
    logic signed [3:0] dy_q, dy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic              serve_dir_q, serve_dir_d;

    logic [10:0]       pad_top;
    logic [10:0]       phys_h, phys_v;
    logic signed [3:0] phys_dx, phys_dy;
    logic              phys_hit, phys_miss;
    logic              serve_done, miss_done;

    assign pad_top    = paddle_top(bus.PADDLE_POSITION);
    assign serve_done = (cnt_q == CNT_W'(SERVE_FRAMES - 1));
    assign miss_done  = (cnt_q == CNT_W'(MISS_FRAMES - 1));

    ball_physics #(.BALL_SIZE(BALL_SIZE)) u_phys (
        .ball_h  (ball_h_q),
        .ball_v  (ball_v_q),
        .dx      (dx_q),
        .dy      (dy_q),
        .pad_top (pad_top),
        .nxt_h   (phys_h),
        .nxt_v   (phys_v),
        .nxt_dx  (phys_dx),
        .nxt_dy  (phys_dy),
        .hit     (phys_hit),
        .miss    (phys_miss)
    );

    always_ff @(posedge SYSTEM_CLOCK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            ball_h_q    <= 11'(CENTER_H);
            ball_v_q    <= 11'(CENTER_V);
            dx_q        <= '0;
            dy_q        <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            lives_q     <= 2'(LIVES);
            serve_dir_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_h_q    <= ball_h_d;
            ball_v_q    <= ball_v_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            serve_dir_q <= serve_dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.FRAME_TICK) begin
            case (state_q)
                ST_IDLE, ST_OVER: if (bus.START) state_d = ST_SERVE;
                ST_SERVE:         if (serve_done) state_d = ST_PLAY;
                ST_PLAY:          if (phys_miss) state_d = ST_MISS;
                ST_MISS:          if (miss_done) state_d = (lives_q == 2'd0) ? ST_OVER : ST_SERVE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ball_h_d    = ball_h_q;
        ball_v_d    = ball_v_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        serve_dir_d = serve_dir_q;
        if (bus.FRAME_TICK) begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (bus.START) begin
                        score_d  = '0;
                        lives_d  = 2'(LIVES);
                        cnt_d    = '0;
                        ball_h_d = 11'(CENTER_H);
                        ball_v_d = 11'(CENTER_V);
                    end
                end
                ST_SERVE: begin
                    if (serve_done) begin
                        // Alternate the vertical launch direction on every serve.
                        cnt_d       = '0;
                        dx_d        = SPEED_V;
                        dy_d        = serve_dir_q ? -SPEED_V : SPEED_V;
                        serve_dir_d = ~serve_dir_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (phys_miss) begin
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                    end else begin
                        ball_h_d = phys_h;
                        ball_v_d = phys_v;
                        dx_d     = phys_dx;
                        dy_d     = phys_dy;
                        if (phys_hit && score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                end
                ST_MISS: begin
                    if (miss_done) begin
                        cnt_d    = '0;
                        ball_h_d = 11'(CENTER_H);
                        ball_v_d = 11'(CENTER_V);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.BALL_H       = ball_h_q;
        bus.BALL_V       = ball_v_q;
        bus.BALL_VISIBLE = (state_q == ST_SERVE) || (state_q == ST_PLAY);
        bus.SCORE        = score_q;
        bus.LIVES_LEFT   = lives_q;
        bus.GAME_STATE   = report_state(state_q);
    end
endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: vector table, directed game sequences, and random play vs a frame-level model.
module tb_pong_game_controller;
    localparam int BALL_SIZE    = 8;
    localparam int SPEED        = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int MISS_FRAMES  = 90;
    localparam int LIVES        = 3;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3, M_MISS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_game_controller_if bus();

    pong_game_controller #(
        .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .SERVE_FRAMES(SERVE_FRAMES),
        .MISS_FRAMES(MISS_FRAMES), .LIVES(LIVES)
    ) dut (
        .SYSTEM_CLOCK (clk),
        .RESET        (rst_n),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int m_state, m_h, m_v, m_dx, m_dy, m_cnt, m_score, m_lives, m_dir;

    task automatic model_reset();
        m_state = M_IDLE; m_h = 385; m_v = 235; m_dx = 0; m_dy = 0;
        m_cnt = 0; m_score = 0; m_lives = LIVES; m_dir = 0;
    endtask

    task automatic model_tick(input bit start, input int pad);
        int nh, nv, pt;
        case (m_state)
            M_IDLE, M_OVER: if (start) begin
                m_state = M_SERVE; m_score = 0; m_lives = LIVES; m_cnt = 0; m_h = 385; m_v = 235;
            end
            M_SERVE: if (m_cnt == SERVE_FRAMES - 1) begin
                m_state = M_PLAY; m_cnt = 0; m_dx = SPEED;
                m_dy = m_dir ? -SPEED : SPEED; m_dir = 1 - m_dir;
            end else m_cnt++;
            M_PLAY: begin
                nh = m_h + m_dx; nv = m_v + m_dy; pt = (pad * 16) % 2048;
                if (m_dx < 0 && nh <= 20 && !(m_v + BALL_SIZE - 1 >= pt && m_v <= pt + 50)) begin
                    m_state = M_MISS; m_lives--; m_cnt = 0;
                end else begin
                    if (m_dy < 0 && nv <= 0) begin m_v = 1; m_dy = -m_dy; end
                    else if (m_dy > 0 && nv + BALL_SIZE >= 478) begin m_v = 477 - BALL_SIZE; m_dy = -m_dy; end
                    else m_v = nv;
                    if (m_dx > 0 && nh + BALL_SIZE >= 778) begin m_h = 777 - BALL_SIZE; m_dx = -m_dx; end
                    else if (m_dx < 0 && nh <= 20) begin
                        m_h = 21; m_dx = -m_dx;
                        if (m_score < 255) m_score++;
                    end else m_h = nh;
                end
            end
            M_MISS: if (m_cnt == MISS_FRAMES - 1) begin
                m_state = (m_lives == 0) ? M_OVER : M_SERVE; m_cnt = 0; m_h = 385; m_v = 235;
            end else m_cnt++;
            default: ;
        endcase
    endtask

    function automatic int exp_gs();
        case (m_state)
            M_IDLE:         return 0;
            M_SERVE, M_MISS: return 1;
            M_PLAY:         return 2;
            default:        return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        int e_vis;
        e_vis = (m_state == M_SERVE || m_state == M_PLAY) ? 1 : 0;
        n_tests++;
        if (int'(bus.GAME_STATE) != exp_gs() || int'(bus.BALL_H) != m_h || int'(bus.BALL_V) != m_v ||
            int'(bus.BALL_VISIBLE) != e_vis || int'(bus.SCORE) != m_score || int'(bus.LIVES_LEFT) != m_lives) begin
            n_fail++;
            $display("FAIL model @cyc %0d: got gs=%0d h=%0d v=%0d vis=%0d sc=%0d lv=%0d, expected gs=%0d h=%0d v=%0d vis=%0d sc=%0d lv=%0d",
                     cyc, bus.GAME_STATE, bus.BALL_H, bus.BALL_V, bus.BALL_VISIBLE, bus.SCORE, bus.LIVES_LEFT,
                     exp_gs(), m_h, m_v, e_vis, m_score, m_lives);
        end
    endtask

    // Drive inputs, advance one clock, update the model, compare at the falling edge.
    task automatic step(input bit r, input bit tick, input bit start, input int pad);
        rst_n = r; bus.FRAME_TICK = tick; bus.START = start; bus.PADDLE_POSITION = 8'(pad);
        @(posedge clk);
        cyc++;
        if (!r) model_reset();
        else if (tick) model_tick(start, pad);
        @(negedge clk);
        check_model();
    endtask

    function automatic int pad_track();
        return m_v >> 4;
    endfunction

    function automatic int pad_away();
        return (m_v < 240) ? 25 : 0;
    endfunction

    typedef struct {
        int rst, tick, start, pad;
        int e_gs, e_h, e_v, e_vis, e_score, e_lives;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int budget, misses, base_lives, prev_state, prev_score, mode;
        tbl[0] = '{0, 0, 0, 0, 0, 385, 235, 0, 0, 3};
        tbl[1] = '{0, 1, 1, 0, 0, 385, 235, 0, 0, 3};
        tbl[2] = '{0, 0, 0, 0, 0, 385, 235, 0, 0, 3};
        tbl[3] = '{1, 0, 1, 0, 0, 385, 235, 0, 0, 3};
        tbl[4] = '{1, 1, 0, 0, 0, 385, 235, 0, 0, 3};
        tbl[5] = '{1, 1, 1, 0, 1, 385, 235, 1, 0, 3};
        tbl[6] = '{1, 1, 1, 9, 1, 385, 235, 1, 0, 3};
        tbl[7] = '{0, 1, 1, 0, 0, 385, 235, 0, 0, 3};
        tbl[8] = '{1, 1, 1, 0, 1, 385, 235, 1, 0, 3};

        model_reset();
        bus.FRAME_TICK = 1'b0; bus.START = 1'b0; bus.PADDLE_POSITION = 8'd0;

        foreach (tbl[i]) begin
            step(tbl[i].rst[0], tbl[i].tick[0], tbl[i].start[0], tbl[i].pad);
            chk($sformatf("vec%0d_state", i), int'(bus.GAME_STATE), tbl[i].e_gs);
            chk($sformatf("vec%0d_h", i), int'(bus.BALL_H), tbl[i].e_h);
            chk($sformatf("vec%0d_v", i), int'(bus.BALL_V), tbl[i].e_v);
            chk($sformatf("vec%0d_vis", i), int'(bus.BALL_VISIBLE), tbl[i].e_vis);
            chk($sformatf("vec%0d_score", i), int'(bus.SCORE), tbl[i].e_score);
            chk($sformatf("vec%0d_lives", i), int'(bus.LIVES_LEFT), tbl[i].e_lives);
        end

        // Serve countdown: 60 ticks from the START tick to PLAY.
        for (int i = 0; i < SERVE_FRAMES - 1; i++) step(1, 1, 0, 0);
        chk("serve_hold", int'(bus.GAME_STATE), 1);
        step(1, 1, 0, 0);
        chk("serve_to_play", int'(bus.GAME_STATE), 2);
        chk("play_entry_h", int'(bus.BALL_H), 385);
        step(1, 1, 0, 0);
        chk("first_move_h", int'(bus.BALL_H), 387);
        chk("first_move_v", int'(bus.BALL_V), 237);

        // Paddle tracks the ball: every left-edge arrival is a hit.
        budget = 4000;
        while (m_score < 2 && budget > 0) begin
            prev_score = m_score;
            step(1, 1, 0, pad_track());
            if (m_score != prev_score) chk("hit_h", int'(bus.BALL_H), 21);
            budget--;
        end
        chk("hit_phase_done", (m_score >= 2) ? 1 : 0, 1);
        chk("hit_score", int'(bus.SCORE), 2);

        // Paddle kept away from the ball until the game ends.
        misses = 0; base_lives = m_lives; budget = 10000;
        while (m_state != M_OVER && budget > 0) begin
            prev_state = m_state;
            step(1, 1, 0, pad_away());
            if (prev_state == M_PLAY && m_state == M_MISS) begin
                misses++;
                chk("miss_lives", int'(bus.LIVES_LEFT), base_lives - misses);
                chk("miss_hidden", int'(bus.BALL_VISIBLE), 0);
            end
            budget--;
        end
        chk("miss_count", misses, 3);
        chk("over_state", int'(bus.GAME_STATE), 3);
        chk("over_hidden", int'(bus.BALL_VISIBLE), 0);
        chk("over_lives", int'(bus.LIVES_LEFT), 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("over_hold_state", int'(bus.GAME_STATE), 3);
        chk("over_hold_score", int'(bus.SCORE), 2);
        step(1, 1, 1, 0);
        chk("restart_state", int'(bus.GAME_STATE), 1);
        chk("restart_lives", int'(bus.LIVES_LEFT), 3);
        chk("restart_score", int'(bus.SCORE), 0);

        // Reset in the middle of play, START held high.
        for (int i = 0; i < SERVE_FRAMES + 10; i++) step(1, 1, 0, pad_track());
        chk("pre_reset_play", int'(bus.GAME_STATE), 2);
        step(0, 1, 1, 0);
        chk("midrst_state", int'(bus.GAME_STATE), 0);
        chk("midrst_h", int'(bus.BALL_H), 385);
        chk("midrst_v", int'(bus.BALL_V), 235);
        chk("midrst_vis", int'(bus.BALL_VISIBLE), 0);
        chk("midrst_lives", int'(bus.LIVES_LEFT), 3);
        step(1, 0, 1, 0);
        chk("midrst_no_tick", int'(bus.GAME_STATE), 0);

        // Random play against the model.
        mode = 0;
        for (int i = 0; i < 20000; i++) begin
            int pad;
            if (i % 512 == 0) mode = int'($urandom_range(0, 2));
            pad = (mode == 0) ? pad_track() : (mode == 1) ? pad_away() : int'($urandom_range(0, 255));
            step($urandom_range(0, 3999) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, pad);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
